// File: rtl/cpu_if.sv
// Control/result bundle between a sequencing layer and the cpu datapath.
// The zero port exists only when CPU_ZERO_FLAG_EN is defined.
interface cpu_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] addressA;
   logic [ADDR_W-1:0] addressB;
   logic [DATA_W-1:0] dataIn;
   logic              asel;
   logic              bsel;
   logic [1:0]        opsel;
   logic [1:0]        outsel;
   logic              oen;
   logic [DATA_W-1:0] outPut;
   logic              over;
`ifdef CPU_ZERO_FLAG_EN
   logic              zero;

   modport master (
      output addressA, addressB, dataIn, asel, bsel, opsel, outsel, oen,
      input  outPut, over, zero
   );

   modport slave (
      input  addressA, addressB, dataIn, asel, bsel, opsel, outsel, oen,
      output outPut, over, zero
   );
`else
   modport master (
      output addressA, addressB, dataIn, asel, bsel, opsel, outsel, oen,
      input  outPut, over
   );

   modport slave (
      input  addressA, addressB, dataIn, asel, bsel, opsel, outsel, oen,
      output outPut, over
   );
`endif
endinterface

// File: rtl/cpu.sv
// Single-cycle datapath: 32x32 register file, 2-operand ALU with signed overflow, registered result.
// Optional registered zero flag enabled by defining CPU_ZERO_FLAG_EN.
module cpu #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic  clk,
   input  logic  rst_n,
   cpu_if.slave  bus
);
   localparam int MSB  = DATA_W - 1;
   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic [DATA_W-1:0] alu;
   logic              alu_ovf;
   logic [DATA_W-1:0] value;
   logic              wr_en;
   logic              ovf_en;

   // Operands read the register file before this edge's write-back lands.
   always_comb begin
      op_a = bus.asel ? regs[bus.addressA] : bus.dataIn;
      op_b = bus.bsel ? regs[bus.addressB] : bus.dataIn;
      sum  = op_a + op_b;
      diff = op_a - op_b;
      alu     = '0;
      alu_ovf = 1'b0;
      case (bus.opsel)
         2'b00: begin
            alu     = sum;
            alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
         end
         2'b01: begin
            alu     = diff;
            alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
         end
         2'b10:   alu = op_a & op_b;
         default: alu = op_a ^ op_b;
      endcase
   end

   always_comb begin
      value  = '0;
      wr_en  = 1'b0;
      ovf_en = 1'b0;
      case (bus.outsel)
         2'b00: begin
            value = op_a;
            wr_en = 1'b1;
         end
         2'b01: begin
            value  = alu;
            wr_en  = 1'b1;
            ovf_en = 1'b1;
         end
         2'b10: begin
            value  = alu;
            ovf_en = 1'b1;
         end
         default: value = regs[bus.addressB];
      endcase
   end

   // Write-back proceeds even when the output is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[bus.addressB] <= value;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.outPut <= '0;
         bus.over   <= 1'b0;
      end else if (bus.oen) begin
         bus.outPut <= value;
         bus.over   <= alu_ovf & ovf_en;
      end else begin
         bus.outPut <= '0;
         bus.over   <= 1'b0;
      end
   end

`ifdef CPU_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.zero <= 1'b0;
      end else begin
         bus.zero <= bus.oen && (value == '0);
      end
   end
`endif
endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: each control word queues its expected result, checked one edge later.
// Also checks the zero flag when CPU_ZERO_FLAG_EN is defined.
module tb_cpu;
   logic clk;
   logic rst_n;
   int   assertions = 0;
   int   failures   = 0;

   typedef struct {
      string       tag;
      logic [31:0] out;
      logic        ovf;
   } exp_t;

   exp_t sb[$];

   cpu_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   cpu #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertions++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one control word between edges and queue what the next edge must produce.
   task automatic applyStimulus(input string tag, input logic [4:0] a_addr, input logic [4:0] b_addr,
                                input logic [31:0] din, input logic a_sel, input logic b_sel,
                                input logic [1:0] op, input logic [1:0] mode, input logic en,
                                input logic [31:0] exp_out, input logic exp_ovf);
      exp_t e;
      @(negedge clk);
      bus.addressA = a_addr;
      bus.addressB = b_addr;
      bus.dataIn   = din;
      bus.asel     = a_sel;
      bus.bsel     = b_sel;
      bus.opsel    = op;
      bus.outsel   = mode;
      bus.oen      = en;
      e.tag = tag;
      e.out = exp_out;
      e.ovf = exp_ovf;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, ".out"}, bus.outPut, e.out);
         checkOutput({e.tag, ".over"}, {31'b0, bus.over}, {31'b0, e.ovf});
`ifdef CPU_ZERO_FLAG_EN
         checkOutput({e.tag, ".zero"}, {31'b0, bus.zero}, {31'b0, (e.out == 32'h0) && !(e.tag == "oen0_store" || e.tag == "oen0_ovf")});
`endif
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bus.addressA = '0;
      bus.addressB = '0;
      bus.dataIn   = '0;
      bus.asel     = 1'b0;
      bus.bsel     = 1'b0;
      bus.opsel    = 2'b00;
      bus.outsel   = 2'b00;
      bus.oen      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.out", bus.outPut, 32'h0);
      checkOutput("reset.over", {31'b0, bus.over}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Stores: outsel 00, asel 0, opsel 01 (ignored)
      applyStimulus("st_r0", 0, 0, 32'h0000_0005, 0, 0, 2'b01, 2'b00, 1, 32'h0000_0005, 0);
      applyStimulus("st_r1", 0, 1, 32'hAAAA_AAAA, 0, 0, 2'b01, 2'b00, 1, 32'hAAAA_AAAA, 0);
      applyStimulus("st_r2", 0, 2, 32'h5555_5555, 0, 0, 2'b01, 2'b00, 1, 32'h5555_5555, 0);
      applyStimulus("st_r3", 0, 3, 32'h0000_000A, 0, 0, 2'b01, 2'b00, 1, 32'h0000_000A, 0);

      // ADD write-back chain
      applyStimulus("add_r2_r0", 2, 0, 32'h0, 1, 1, 2'b00, 2'b01, 1, 32'h5555_555A, 0);
      applyStimulus("add_r1_r2", 1, 2, 32'h0, 1, 1, 2'b00, 2'b01, 1, 32'hFFFF_FFFF, 0);
      applyStimulus("add_r0_r3", 0, 3, 32'h0, 1, 1, 2'b00, 2'b01, 1, 32'h5555_5564, 0);

      // SUB
      applyStimulus("st_r5", 0, 5, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 1, 32'hFFFF_FFFF, 0);
      applyStimulus("st_r4", 0, 4, 32'h0000_0001, 0, 0, 2'b00, 2'b00, 1, 32'h0000_0001, 0);
      applyStimulus("sub_r5_r4", 5, 4, 32'h0, 1, 1, 2'b01, 2'b01, 1, 32'hFFFF_FFFE, 0);
      applyStimulus("sub_r2_r0", 2, 0, 32'h0, 1, 1, 2'b01, 2'b01, 1, 32'hAAAA_AAA5, 0);

      // Wrap and overflow, no write-back
      applyStimulus("st_r8", 0, 8, 32'h5555_5555, 0, 0, 2'b00, 2'b00, 1, 32'h5555_5555, 0);
      applyStimulus("st_r9", 0, 9, 32'h0000_0001, 0, 0, 2'b00, 2'b00, 1, 32'h0000_0001, 0);
      applyStimulus("add_wrap", 0, 8, 32'hAAAA_AAAB, 0, 1, 2'b00, 2'b10, 1, 32'h0000_0000, 0);
      applyStimulus("add_ovf", 0, 9, 32'h7FFF_FFFF, 0, 1, 2'b00, 2'b10, 1, 32'h8000_0000, 1);
      applyStimulus("sub_ovf", 0, 9, 32'h8000_0000, 0, 1, 2'b01, 2'b10, 1, 32'h7FFF_FFFF, 1);
      applyStimulus("add_ffff_1", 0, 9, 32'hFFFF_FFFF, 0, 1, 2'b00, 2'b10, 1, 32'h0000_0000, 0);
      applyStimulus("and_op", 0, 1, 32'hF0F0_F0F0, 0, 1, 2'b10, 2'b10, 1, 32'hA0A0_A0A0, 0);
      applyStimulus("xor_op", 0, 1, 32'hF0F0_F0F0, 0, 1, 2'b11, 2'b10, 1, 32'h5A5A_5A5A, 0);
      applyStimulus("peek_r8", 0, 8, 32'h0, 0, 0, 2'b00, 2'b11, 1, 32'h5555_5555, 0);

      // Read-back
      applyStimulus("st_r6", 0, 6, 32'h0000_00C8, 0, 0, 2'b00, 2'b00, 1, 32'h0000_00C8, 0);
      applyStimulus("st_r7", 0, 7, 32'h0000_012C, 0, 0, 2'b00, 2'b00, 1, 32'h0000_012C, 0);
      applyStimulus("add_r6_r7", 6, 7, 32'h0, 1, 1, 2'b00, 2'b01, 1, 32'h0000_01F4, 0);
      applyStimulus("rd_r7", 7, 7, 32'h0, 1, 0, 2'b00, 2'b00, 1, 32'h0000_01F4, 0);
      applyStimulus("rd_r3", 3, 3, 32'h0, 1, 0, 2'b00, 2'b00, 1, 32'h5555_5564, 0);
      applyStimulus("rd_r1", 1, 1, 32'h0, 1, 0, 2'b00, 2'b00, 1, 32'hAAAA_AAAA, 0);
      applyStimulus("peek_r0", 0, 0, 32'h0, 0, 0, 2'b00, 2'b11, 1, 32'hAAAA_AAA5, 0);

      // Same-register ADD reads old value, next op sees the write
      applyStimulus("add_r9_r9", 9, 9, 32'h0, 1, 1, 2'b00, 2'b01, 1, 32'h0000_0002, 0);
      applyStimulus("peek_r9", 0, 9, 32'h0, 0, 0, 2'b00, 2'b11, 1, 32'h0000_0002, 0);

      // Output disabled: result gated, write-back kept
      applyStimulus("oen0_store", 0, 11, 32'h0000_1234, 0, 0, 2'b00, 2'b00, 0, 32'h0000_0000, 0);
      applyStimulus("oen0_ovf", 0, 9, 32'h7FFF_FFFF, 0, 1, 2'b00, 2'b10, 0, 32'h0000_0000, 0);
      applyStimulus("rd_r11", 11, 11, 32'h0, 1, 0, 2'b00, 2'b00, 1, 32'h0000_1234, 0);

      // Leave a nonzero result with overflow, then reset between edges
      applyStimulus("add_imm_ovf", 0, 12, 32'h4000_0000, 0, 0, 2'b00, 2'b10, 1, 32'h8000_0000, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset.out", bus.outPut, 32'h0);
      checkOutput("midreset.over", {31'b0, bus.over}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("heldreset.out", bus.outPut, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("post_rst_r1", 0, 1, 32'h0, 0, 0, 2'b00, 2'b11, 1, 32'h0000_0000, 0);
      applyStimulus("post_rst_r3", 3, 3, 32'h0, 1, 0, 2'b00, 2'b00, 1, 32'h0000_0000, 0);
      applyStimulus("post_rst_r11", 0, 11, 32'h0, 0, 0, 2'b00, 2'b11, 1, 32'h0000_0000, 0);

      @(negedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
